mem_sweep_ctrl: RTL and testbench

Sequencer that owns both ports of one block-RAM `memory` instance and walks its whole address space. It optionally overwrites the array with a deterministic pattern and then reads every word back, accumulating a checksum. The checksum is compared against an expected value, so the test harness can confirm that a bitstream memory reinit landed the intended contents. It sits between the harness control registers and the `memory` instance, replacing direct harness drive of `raddr`, `waddr` and `din`.

---
 rtl/mem_sweep_ctrl_pkg.sv | 20 ++
 rtl/mem_sweep_ctrl_if.sv | 31 +++
 rtl/mem_sweep_ctrl_acc.sv | 38 +++
 rtl/mem_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_sweep_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sweep_ctrl_pkg.sv
// Shared types and constants for the block-RAM sweep controller.
package mem_sweep_pkg;

    localparam int CHECKSUM_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_DRAIN,
        S_DONE
    } sweep_state_t;

    typedef enum logic [1:0] {
        MODE_VERIFY      = 2'd0,
        MODE_FILL        = 2'd1,
        MODE_FILL_VERIFY = 2'd2
    } sweep_mode_t;

endpackage

// File: rtl/mem_sweep_ctrl_if.sv
// Harness control and RAM port bundle for mem_sweep_ctrl.
interface mem_sweep_ctrl_if #(
    parameter int WID_MEM = 4
);
    import mem_sweep_pkg::*;

    logic                  start;
    logic [1:0]            mode;
    logic [WID_MEM-1:0]    seed;
    logic [CHECKSUM_W-1:0] expected_sum;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [CHECKSUM_W-1:0] checksum;
    logic [31:0]           mem_raddr;
    logic [31:0]           mem_waddr;
    logic [WID_MEM-1:0]    mem_din;
    logic                  mem_we;
    logic [WID_MEM-1:0]    mem_dout;

    modport master (
        output start, mode, seed, expected_sum, mem_dout,
        input  busy, done, pass, checksum, mem_raddr, mem_waddr, mem_din, mem_we
    );

    modport slave (
        input  start, mode, seed, expected_sum, mem_dout,
        output busy, done, pass, checksum, mem_raddr, mem_waddr, mem_din, mem_we
    );

endinterface

// File: rtl/mem_sweep_ctrl_acc.sv
// Read-data checksum: one-cycle delayed valid, 32-bit wrapping sum, final compare.
module mem_sweep_acc
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  eval,
    input  logic [WID_MEM-1:0]    rd_data,
    input  logic [CHECKSUM_W-1:0] expected,
    output logic [CHECKSUM_W-1:0] checksum,
    output logic                  pass
);

    logic rd_valid;

    // RAM data lags its address by one cycle, so the valid flag does too.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            checksum <= '0;
            pass     <= 1'b0;
        end else begin
            rd_valid <= en;
            if (clear) begin
                checksum <= '0;
                pass     <= 1'b0;
            end else begin
                if (rd_valid) checksum <= checksum + CHECKSUM_W'(rd_data);
                if (eval)     pass     <= (checksum == expected);
            end
        end
    end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Block-RAM sweep sequencer: optional pattern fill, then full read-back checksum.
// The fill path exists only when MEM_SWEEP_FILL_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FILL  | writing seed+addr to every word
// S_READ  | issuing read addresses
// S_DRAIN | absorbing the last read word
// S_DONE  | one-cycle completion, pass evaluated
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM   = 4,
    parameter int DEPTH_MEM = 32768
) (
    input  logic             clk,
    input  logic             reset,
    mem_sweep_ctrl_if.slave  bus
);

    localparam int            AW        = $clog2(DEPTH_MEM);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH_MEM - 1);

    sweep_state_t          state, state_n;
    logic [AW-1:0]         addr, addr_n;
    logic                  accept;
    logic                  busy_q;
    logic                  done_q;
    logic [CHECKSUM_W-1:0] exp_q;
    logic                  mode_fill;
    logic                  mode_fv;

    // busy also covers the done cycle, so a start there is ignored
    assign accept = (state == S_IDLE) && !busy_q && bus.start;

`ifdef MEM_SWEEP_FILL_EN
    logic               fv_q, fv_n;
    logic [WID_MEM-1:0] seed_q, seed_v;
    logic               we_q;
    logic [WID_MEM-1:0] din_q;

    assign mode_fill = (bus.mode == MODE_FILL) || (bus.mode == MODE_FILL_VERIFY);
    assign mode_fv   = (bus.mode == MODE_FILL_VERIFY);
    assign seed_v    = accept ? bus.seed : seed_q;
`else
    assign mode_fill = 1'b0;
    assign mode_fv   = 1'b0;
`endif

    always_comb begin
        state_n = state;
        addr_n  = addr;
`ifdef MEM_SWEEP_FILL_EN
        fv_n    = fv_q;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    addr_n  = '0;
                    state_n = mode_fill ? S_FILL : S_READ;
`ifdef MEM_SWEEP_FILL_EN
                    fv_n    = mode_fv;
`endif
                end
            end
`ifdef MEM_SWEEP_FILL_EN
            S_FILL: begin
                addr_n = addr + 1'b1;
                if (addr == ADDR_LAST) state_n = fv_q ? S_READ : S_DONE;
            end
`endif
            S_READ: begin
                addr_n = addr + 1'b1;
                if (addr == ADDR_LAST) state_n = S_DRAIN;
            end
            S_DRAIN: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            addr   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            exp_q  <= '0;
        end else begin
            state  <= state_n;
            addr   <= addr_n;
            done_q <= (state == S_DONE);
            if (accept) begin
                busy_q <= 1'b1;
                exp_q  <= bus.expected_sum;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef MEM_SWEEP_FILL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fv_q   <= 1'b0;
            seed_q <= '0;
            we_q   <= 1'b0;
            din_q  <= '0;
        end else begin
            fv_q   <= fv_n;
            seed_q <= seed_v;
            we_q   <= (state_n == S_FILL);
            din_q  <= (state_n == S_FILL) ? seed_v + WID_MEM'(addr_n) : '0;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = 32'(addr);
    assign bus.mem_din   = din_q;
`else
    assign bus.mem_we    = 1'b0;
    assign bus.mem_waddr = '0;
    assign bus.mem_din   = '0;
`endif

    assign bus.mem_raddr = 32'(addr);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    mem_sweep_acc #(
        .WID_MEM (WID_MEM)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .en       (state == S_READ),
        .eval     (state == S_DONE),
        .rd_data  (bus.mem_dout),
        .expected (exp_q),
        .checksum (bus.checksum),
        .pass     (bus.pass)
    );

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench for mem_sweep_ctrl with a 16x4 synchronous RAM model.
module tb_mem_sweep_ctrl;
    import mem_sweep_pkg::*;

    localparam int W = 4;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_sweep_ctrl_if #(.WID_MEM(W)) bus ();

    mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] ram [D];
    logic         preload_en = 1'b0;
    logic [W-1:0] preload_val = '0;
    logic         cnt_clr = 1'b0;
    int           we_cnt = 0;
    int           done_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < D; i++) ram[i] <= preload_val;
        end else if (bus.mem_we) begin
            ram[bus.mem_waddr[3:0]] <= bus.mem_din;
        end
        bus.mem_dout <= ram[bus.mem_raddr[3:0]];
    end

    always @(posedge clk) begin
        if (cnt_clr) begin
            we_cnt   <= 0;
            done_cnt <= 0;
        end else begin
            if (bus.mem_we) we_cnt <= we_cnt + 1;
            if (bus.done)   done_cnt <= done_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [W-1:0] v);
        preload_val = v;
        preload_en  = 1'b1;
        step();
        preload_en  = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    // Pulses start for one edge, then counts edges until done is seen.
    task automatic run_sweep(input logic [1:0] m, input logic [W-1:0] s,
                             input logic [31:0] e, output int cyc);
        bus.mode = m;
        bus.seed = s;
        bus.expected_sum = e;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", bus.pass); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.mem_we); end
        checks++; if (bus.checksum !== 32'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", bus.checksum); end
        checks++; if (bus.mem_raddr !== 32'd0) begin errors++; $display("FAIL reset_raddr got %0d want 0", bus.mem_raddr); end
        checks++; if (bus.mem_waddr !== 32'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", bus.mem_waddr); end
        checks++; if (bus.mem_din !== 4'd0) begin errors++; $display("FAIL reset_din got %0d want 0", bus.mem_din); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_verify_pass();
        int cyc;
        preload(4'hF);
        run_sweep(2'd0, 4'd0, 32'd240, cyc);
        checks++; if (cyc != 18) begin errors++; $display("FAIL verify_latency got %0d want 18", cyc); end
        checks++; if (bus.checksum !== 32'd240) begin errors++; $display("FAIL verify_sum got %0d want 240", bus.checksum); end
        checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL verify_pass got %b want 1", bus.pass); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL verify_busy_at_done got %b want 1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL verify_busy_after got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL verify_done_pulse got %b want 0", bus.done); end
        checks++; if (bus.pass !== 1'b1 || bus.checksum !== 32'd240) begin errors++; $display("FAIL verify_hold got pass=%b sum=%0d want 1/240", bus.pass, bus.checksum); end
    endtask

    task automatic test_verify_fail();
        int cyc;
        run_sweep(2'd0, 4'd0, 32'd239, cyc);
        checks++; if (bus.checksum !== 32'd240) begin errors++; $display("FAIL mism_sum got %0d want 240", bus.checksum); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL mism_pass got %b want 0", bus.pass); end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.mode = 2'd0;
        bus.expected_sum = 32'd240;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin step(); cyc++; end
        // start during the done cycle must be dropped
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done got busy=%b want 0", bus.busy); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
        checks++; if (bus.pass !== 1'b0 || bus.checksum !== 32'd0) begin errors++; $display("FAIL b2b_clear got pass=%b sum=%0d want 0/0", bus.pass, bus.checksum); end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin step(); cyc++; end
        checks++; if (cyc != 18 || bus.checksum !== 32'd240) begin errors++; $display("FAIL b2b_second got cyc=%0d sum=%0d want 18/240", cyc, bus.checksum); end
        step();
    endtask

    task automatic test_start_while_busy(input logic [31:0] exp_sum);
        int cyc;
        clear_counts();
        bus.mode = 2'd0;
        bus.expected_sum = exp_sum;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 5;
        while (bus.done !== 1'b1 && cyc < 200) begin step(); cyc++; end
        checks++; if (cyc != 18) begin errors++; $display("FAIL busy_start_latency got %0d want 18", cyc); end
        checks++; if (bus.checksum !== exp_sum) begin errors++; $display("FAIL busy_start_sum got %0d want %0d", bus.checksum, exp_sum); end
        repeat (30) step();
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_dones got %0d want 1", done_cnt); end
    endtask

`ifdef MEM_SWEEP_FILL_EN
    task automatic test_fill_verify();
        int cyc;
        preload(4'h0);
        clear_counts();
        bus.mode = 2'd2;
        bus.seed = 4'd3;
        bus.expected_sum = 32'd120;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 32'd0 || bus.mem_din !== 4'd3) begin
            errors++; $display("FAIL fv_first_write got we=%b wa=%0d din=%0d want 1/0/3", bus.mem_we, bus.mem_waddr, bus.mem_din); end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin step(); cyc++; end
        checks++; if (cyc != 34) begin errors++; $display("FAIL fv_latency got %0d want 34", cyc); end
        checks++; if (bus.checksum !== 32'd120 || bus.pass !== 1'b1) begin errors++; $display("FAIL fv_result got sum=%0d pass=%b want 120/1", bus.checksum, bus.pass); end
        checks++; if (we_cnt != 16) begin errors++; $display("FAIL fv_we_cycles got %0d want 16", we_cnt); end
        checks++; if (ram[0] !== 4'd3 || ram[12] !== 4'd15 || ram[15] !== 4'd2) begin
            errors++; $display("FAIL fv_ram got %0d/%0d/%0d want 3/15/2", ram[0], ram[12], ram[15]); end
        step();
    endtask

    task automatic test_fill_only();
        int cyc;
        clear_counts();
        run_sweep(2'd1, 4'd5, 32'd0, cyc);
        checks++; if (cyc != 17) begin errors++; $display("FAIL fill_latency got %0d want 17", cyc); end
        checks++; if (we_cnt != 16) begin errors++; $display("FAIL fill_we_cycles got %0d want 16", we_cnt); end
        checks++; if (bus.checksum !== 32'd0) begin errors++; $display("FAIL fill_sum got %0d want 0", bus.checksum); end
        checks++; if (ram[0] !== 4'd5 || ram[10] !== 4'd15 || ram[11] !== 4'd0) begin
            errors++; $display("FAIL fill_ram got %0d/%0d/%0d want 5/15/0", ram[0], ram[10], ram[11]); end
        step();
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        preload(4'hF);
        bus.mode = 2'd1;
        bus.seed = 4'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        checks++; if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL midrst_state got busy=%b we=%b want 0/0", bus.busy, bus.mem_we); end
        checks++; if (bus.mem_waddr !== 32'd0) begin errors++; $display("FAIL midrst_addr got %0d want 0", bus.mem_waddr); end
        reset = 1'b0;
        step();
        run_sweep(2'd0, 4'd0, 32'd156, cyc);
        checks++; if (bus.checksum !== 32'd156 || bus.pass !== 1'b1) begin errors++; $display("FAIL midrst_sum got %0d pass=%b want 156/1", bus.checksum, bus.pass); end
        step();
    endtask
`else
    task automatic test_no_fill();
        int cyc;
        preload(4'hF);
        clear_counts();
        run_sweep(2'd1, 4'd7, 32'd240, cyc);
        checks++; if (cyc != 18) begin errors++; $display("FAIL nofill_latency got %0d want 18", cyc); end
        checks++; if (bus.checksum !== 32'd240 || bus.pass !== 1'b1) begin errors++; $display("FAIL nofill_result got sum=%0d pass=%b want 240/1", bus.checksum, bus.pass); end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL nofill_we got %0d want 0", we_cnt); end
        step();
        run_sweep(2'd2, 4'd7, 32'd240, cyc);
        checks++; if (cyc != 18 || bus.checksum !== 32'd240) begin errors++; $display("FAIL nofill_mode2 got cyc=%0d sum=%0d want 18/240", cyc, bus.checksum); end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL nofill_mode2_we got %0d want 0", we_cnt); end
        step();
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.mode = 2'd0;
        bus.seed = '0;
        bus.expected_sum = '0;
        test_reset();
        test_verify_pass();
        test_verify_fail();
        test_back_to_back();
`ifdef MEM_SWEEP_FILL_EN
        test_fill_verify();
        test_fill_only();
        test_start_while_busy(32'd120);
        test_reset_mid_fill();
`else
        test_start_while_busy(32'd240);
        test_no_fill();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
